// File: rtl/mealy_pkg.sv
// Shared types and constants for the arbitrated Mealy stepping core.
// Optional per-requester step counters: define MEALY_STEP_COUNT_EN.
package mealy_pkg;

    localparam int STATE_W = 4;
    localparam int NUM_REQ = 2;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

    localparam state_t S0 = 4'd0;
    localparam state_t S1 = 4'd1;
    localparam state_t S2 = 4'd2;
    localparam state_t S3 = 4'd3;
    localparam state_t S4 = 4'd4;
    localparam state_t S5 = 4'd5;

    function automatic logic [NUM_REQ-1:0] onehot(input req_idx_t idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mealy_next_state.sv
// Combinational transition function of the 6-state Mealy core.
// Unused encodings fall back to S0 regardless of the input bit.
module mealy_next_state
    import mealy_pkg::*;
(
    input  state_t cur,
    input  logic   in_b,
    output state_t nxt
);

    always_comb begin
        nxt = S0;
        unique case (cur)
            S0:      nxt = in_b ? S3 : S1;
            S1:      nxt = in_b ? S5 : S2;
            S2:      nxt = in_b ? S0 : S3;
            S3:      nxt = in_b ? S1 : S4;
            S4:      nxt = in_b ? S2 : S5;
            S5:      nxt = in_b ? S4 : S0;
            default: nxt = S0;
        endcase
    end

endmodule

// File: rtl/mealy_step_arbiter.sv
// Round-robin arbiter granting single steps of a shared Mealy core.
// Optional per-requester step counters: define MEALY_STEP_COUNT_EN.
module mealy_step_arbiter
    import mealy_pkg::*;
#(
    parameter int GAP   = 0,
    parameter int GAP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] in_bit,
    input  logic               clr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [STATE_W-1:0] state,
    output logic               step_valid,
    output logic               busy
`ifdef MEALY_STEP_COUNT_EN
    ,
    output logic [7:0]         cnt0,
    output logic [7:0]         cnt1
`endif
);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               sv_q, sv_d;
    logic               busy_q, busy_d;
    logic [GAP_W-1:0]   cd_q, cd_d;
    req_idx_t           lw_q, lw_d;

    req_idx_t           winner;
    logic               eligible;
    state_t             stepped;

    mealy_next_state u_next (
        .cur  (state_q),
        .in_b (in_bit[winner]),
        .nxt  (stepped)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S0;
            gnt_q   <= '0;
            sv_q    <= 1'b0;
            busy_q  <= 1'b0;
            cd_q    <= '0;
            lw_q    <= req_idx_t'(1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sv_q    <= sv_d;
            busy_q  <= busy_d;
            cd_q    <= cd_d;
            lw_q    <= lw_d;
        end
    end

    // Contention goes to whoever did not win last.
    always_comb begin
        winner = ~lw_q;
        unique case (1'b1)
            (req == 2'b01): winner = req_idx_t'(0);
            (req == 2'b10): winner = req_idx_t'(1);
            default:        winner = ~lw_q;
        endcase
    end

    always_comb begin
        eligible = !clr && (cd_q == '0) && (req != '0);
        state_d  = state_q;
        gnt_d    = '0;
        sv_d     = 1'b0;
        lw_d     = lw_q;
        cd_d     = (cd_q != '0) ? cd_q - GAP_W'(1) : cd_q;
        if (clr) begin
            state_d = S0;
            cd_d    = '0;
        end else if (eligible) begin
            state_d = stepped;
            gnt_d   = onehot(winner);
            sv_d    = 1'b1;
            lw_d    = winner;
            cd_d    = GAP_W'(GAP);
        end
        busy_d = (cd_d != '0);
    end

    always_comb begin
        gnt        = gnt_q;
        state      = state_q;
        step_valid = sv_q;
        busy       = busy_q;
    end

`ifdef MEALY_STEP_COUNT_EN
    // Saturating counters; clr deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt0 <= 8'd0;
            cnt1 <= 8'd0;
        end else begin
            if (gnt_d[0] && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
            if (gnt_d[1] && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: doc/mealy_step_arbiter.md
Name: mealy_step_arbiter

Overview:
- Shares one 6-state Mealy stepping core between two requesters (player A = 0, player B = 1 in the Pong top level).
- Each granted request advances the core by exactly one transition, using that requester's input bit.
- Round-robin arbitration with a programmable cooldown between steps paces game events.
- The block replaces the free-running per-clock stepping with controlled, attributable steps.

Parameters:
- GAP, default 0: idle cycles forced after each granted step (0 = a step may occur every cycle).
- GAP_W, default 4: width of the cooldown counter; GAP must be < 2^GAP_W.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- req  input  2  level request per requester; held until that requester's gnt is seen
- in_bit  input  2  Mealy input bit per requester, sampled only for the winner
- clr  input  1  synchronous clear of the core state, arbitration history untouched
- gnt  output  2  one-hot, one-cycle pulse marking the requester whose step was taken
- state  output  4  current core state, 0..5
- step_valid  output  1  one-cycle pulse, high with any gnt
- busy  output  1  high while the cooldown counter is non-zero

Behaviour:
- Reset: the synchronous check is `!reset` at a rising clk edge. It sets state=0, gnt=00, step_valid=0, busy=0, cooldown=0, last_winner=1 (so requester 0 wins the first contention).
- Priority at each edge: reset > clr > step > cooldown decrement.
- Transition table, next(state, in) shown as in=0/in=1:
  - 0 -> 1/3
  - 1 -> 2/5
  - 2 -> 3/0
  - 3 -> 4/1
  - 4 -> 5/2
  - 5 -> 0/4
  - any encoding 6..15 -> 0 regardless of input.
- Eligible edge: reset high, clr low, cooldown==0, req!=00.
- Winner selection:
  - req=01 -> 0.
  - req=10 -> 1.
  - req=11 -> the requester other than last_winner.
- On an eligible edge the following update together and are visible the cycle after the edge:
  - state <= next(state, in_bit[winner])
  - gnt <= onehot(winner)
  - step_valid <= 1
  - last_winner <= winner
  - cooldown <= GAP
- Non-eligible edge: gnt=00 and step_valid=0; cooldown decrements if non-zero; state holds.
- Latency: 1 cycle from a sampled req to gnt and the updated state.
- Requester protocol: drop req in the cycle gnt is seen, or request again. A held req is re-granted per the arbitration rules, every GAP+1 cycles.
- With req=11 held and GAP=0: grants alternate 01, 10, 01, … on consecutive cycles.
- clr together with req:
  - clr wins: state=0, no gnt, cooldown forced to 0.
  - last_winner is unchanged.
  - The pending req is served at the next edge.
- Reset mid-cooldown: all registers return to reset values immediately at that edge.
- busy = (cooldown != 0), registered.
- A request arriving during cooldown waits; there is no queueing beyond the req level itself.

Optional Feature:
- Macro: MEALY_STEP_COUNT_EN.
- When defined, the block adds:
  - outputs cnt0 and cnt1, each 8 bits: per-requester granted-step counters.
  - Counters saturate at 255.
  - Counters clear on reset, not on clr.
  - Counters increment at the same edge the corresponding gnt is set.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package mealy_pkg holds:
  - STATE_W=4
  - state constants S0..S5
  - NUM_REQ=2
  - a requester-index type.
- One sub-module, mealy_next_state: purely combinational (state, in) -> next state, implementing the table above including the default-to-0 rule.
- Arbitration, cooldown and counters live in mealy_step_arbiter.

Test Plan:
- Reset then single requester: reset low 2 cycles; req=01 held, in_bit[0]=0, GAP=0 -> state sequence 1,2,3,4,5,0 on successive cycles, gnt=01 every cycle.
- Contention: req=11, in_bit=10 held, GAP=0 -> gnt 01,10,01,10; state 0->1 (A, in 0)->5 (B, in 1)->0 (A, in 0)->3 (B, in 1).
- Cooldown: GAP=3, req=01 pulsed in cycle 0 and held -> gnts at cycles 1,5,9; busy high for 3 cycles after each gnt.
- clr collision: in state 4, assert clr and req=10 together -> state=0, gnt=00; next cycle gnt=10, state=next(0, in_bit[1]).
- Reset during cooldown: GAP=5, reset low 2 cycles after a grant -> busy=0, state=0; first post-reset contention on req=11 grants requester 0.
- Counters (MEALY_STEP_COUNT_EN): 300 grants to requester 0 -> cnt0=255, cnt1=0; clr leaves cnt0=255.
